filter_decim_buffer: RTL



---
 rtl/filter_decim_buffer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/filter_decim_buffer.sv
// Averages every DECIM valid samples into one result and queues results in a small output FIFO.
// Define FILTER_DECIM_ROUND_EN for round-half-up averaging with a clamp at +127 (default: truncation).
module filter_decim_buffer #(
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [7:0]             sample_in,
    input  logic                          sample_valid,
    output logic signed [7:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          ovf_flag,
    output logic [7:0]                    ovf_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int SHIFT = $clog2(DECIM);
    localparam int ACC_W = 8 + SHIFT;
    localparam int PH_W  = SHIFT;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [PH_W-1:0]  PH_LAST_ACC = PH_W'(DECIM - 2);
    localparam logic [LVL_W-1:0] LVL_FULL    = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_ACC,
        ST_EMIT
    } state_e;

    // Group sum to output sample; the sum of DECIM 8-bit samples always fits ACC_W bits.
    function automatic logic signed [7:0] decim_result(input logic signed [ACC_W-1:0] sum);
`ifdef FILTER_DECIM_ROUND_EN
        localparam int RND_W = ACC_W + 1;
        logic signed [RND_W-1:0] rnd;
        logic signed [RND_W-1:0] shifted;
        rnd     = {sum[ACC_W-1], sum} + RND_W'(DECIM / 2);
        shifted = rnd >>> SHIFT;
        if (shifted > $signed(RND_W'(127))) begin
            return 8'sd127;
        end
        return shifted[7:0];
`else
        logic signed [ACC_W-1:0] shifted;
        shifted = sum >>> SHIFT;
        return shifted[7:0];
`endif
    endfunction

    state_e                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] sum;

    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    ovf_flag_q, ovf_flag_d;
    logic [7:0]              ovf_count_q, ovf_count_d;
    logic signed [7:0]       mem_q [FIFO_DEPTH];

    logic                    push, pop, full, push_ok, drop;
    logic signed [7:0]       result;

    assign sum    = acc_q + {{SHIFT{sample_in[7]}}, sample_in};
    assign result = decim_result(sum);

    // Phase FSM: accumulate DECIM-1 samples, the next one completes and emits the group.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        acc_d   = acc_q;
        push    = 1'b0;
        if (sample_valid) begin
            case (state_q)
                ST_ACC: begin
                    acc_d   = sum;
                    phase_d = phase_q + PH_W'(1);
                    state_d = (phase_q == PH_LAST_ACC) ? ST_EMIT : ST_ACC;
                end
                ST_EMIT: begin
                    acc_d   = '0;
                    phase_d = '0;
                    state_d = ST_ACC;
                    push    = 1'b1;
                end
                default: begin
                    acc_d   = '0;
                    phase_d = '0;
                    state_d = ST_ACC;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
            phase_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            acc_q   <= acc_d;
        end
    end

    // A pop frees the slot on the same edge, so a full FIFO still accepts a push when popping.
    assign full    = (level_q == LVL_FULL);
    assign pop     = out_valid && out_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        ovf_flag_d  = ovf_flag_q;
        ovf_count_d = ovf_count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (drop) begin
            ovf_flag_d = 1'b1;
            if (ovf_count_q != 8'hFF) begin
                ovf_count_d = ovf_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_flag_q  <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_flag_q  <= ovf_flag_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    // Storage is never reset; out_data is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= result;
        end
    end

    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : 8'sd0;
    assign ovf_flag   = ovf_flag_q;
    assign ovf_count  = ovf_count_q;
    assign fifo_level = level_q;

endmodule
